dino_jump_ctrl: RTL
===================

DINO_JUMP_CTRL -- requirements
Module: dino_jump_ctrl

Interface
REQ-001 Parameter GROUND_Y, default 9'd146: resting top-left row of the sprite; legal range 124..511.
REQ-002 Parameter LEG_DIV, default 16: number of ticks between leg-frame toggles while grounded; legal range 1..255.
REQ-003 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-low.
REQ-005 Port tick, input, 1: motion step strobe; one clk cycle wide when asserted.
REQ-006 Port jump_req, input, 1: jump request; level is sampled on every clk edge.
REQ-007 Port freeze, input, 1: game-over hold; when high, all state is held.
REQ-008 Port y, output, 9: current sprite top row, registered.
REQ-009 Port busy, output, 1: high in every state except IDLE, registered.
REQ-010 Port leg, output, 1: walking frame select; 0 selects the left-leg frame, 1 selects the right-leg frame.
REQ-011 Port jump_done, output, 1: one-cycle pulse on landing.
REQ-012 Port phase, output, 3: state encoding; IDLE=0, R6=1, R4=2, R2=3, F2=4, F4=5, F6=6.

Function
REQ-013 FSM states and per-tick y step/step counts SHALL be:
- R6: -6, 10 ticks
- R4: -4, 10 ticks
- R2: -2, 12 ticks
- F2: +2, 12 ticks
- F4: +4, 10 ticks
- F6: +6, 10 ticks
REQ-014 A 4-bit step counter SHALL count ticks within a phase; it clears on each phase change.
REQ-015 On the tick that completes a phase's count, the FSM SHALL move to the next phase.
REQ-016 IDLE with jump_req=1 SHALL enter R6 on the next edge; busy rises on that same edge.
REQ-017 When jump_req and tick coincide in IDLE, the tick SHALL NOT move y; the first move occurs on the next tick.
REQ-018 The y update and the counter increment SHALL occur on the same edge as the tick; y has 1-cycle latency from tick.
REQ-019 Peak y SHALL equal GROUND_Y-124, reached at the end of R2; y after F6 completes SHALL equal GROUND_Y exactly.
REQ-020 Arithmetic SHALL be 9-bit unsigned; with legal GROUND_Y no wrap occurs.
REQ-021 On the edge completing F6: y=GROUND_Y, jump_done=1 for exactly one cycle, state -> IDLE.
REQ-022 jump_req asserted in R6..F4 SHALL be ignored and not stored.
REQ-023 jump_req asserted during F6 SHALL set a one-deep pending flag; further requests while the flag is set are ignored.
REQ-024 On landing with the pending flag set, the FSM SHALL go directly to R6.
REQ-025 In the pending-landing case, jump_done still pulses, busy stays 1, and the pending flag clears.
REQ-026 freeze=1 SHALL hold the FSM, counters, y, leg and the pending flag, and SHALL block jump_req acceptance.
REQ-027 freeze=1 SHALL force jump_done=0; a landing that was blocked by freeze occurs on the first unfrozen tick.
REQ-028 While in IDLE, a leg divider SHALL count ticks; on reaching LEG_DIV it toggles leg and clears.
REQ-029 While busy, leg and the leg divider SHALL hold.
REQ-030 tick=0 SHALL change nothing except the request and pending logic.

Reset
REQ-031 rst=0 at a clk edge SHALL force the following, regardless of other inputs or state (including mid-jump):
- state=IDLE, phase=0
- y=GROUND_Y
- busy=0, jump_done=0
- leg=0, leg divider=0
- step counter=0, pending flag=0
REQ-032 On the first edge with rst=1, the block SHALL behave per Function; a jump_req held through reset release starts a jump on that edge.

Verification
REQ-033 Full jump: rst release, jump_req pulse, 64 ticks spaced 4 cycles apart -> y sequence 140,134,...,86,82,...,46,44,...,22,24,...,146; then jump_done single pulse, busy=0, phase=0.
REQ-034 Coincident start: jump_req and tick in the same cycle in IDLE -> y=146 after that edge, y=140 only after the following tick.
REQ-035 Requests mid-air: jump_req pulses in R4 and F2 are ignored; a pulse in F6 leads to landing, then immediately R6 with busy held at 1 and one jump_done pulse.
REQ-036 Freeze: freeze=1 for 20 cycles in R2 with ticks present -> y, phase and leg constant throughout; motion resumes from the same y/count after release.
REQ-037 Reset mid-jump: rst=0 in F4 -> the next edge gives y=146, busy=0, leg=0, phase=0, and no jump_done pulse.
REQ-038 Leg animation: IDLE with LEG_DIV=16 and 48 ticks -> leg toggles exactly 3 times; during a jump leg holds its value.

Source files
------------

// File: rtl/dino_jump_ctrl.sv
// Jump/walk controller for a runner sprite: a six-phase parabolic-ish jump
// driven by a tick strobe, a one-deep jump buffer during descent, and a leg animation divider.
module dino_jump_ctrl #(
  parameter logic [8:0] GROUND_Y = 9'd146,
  parameter int         LEG_DIV  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       jump_req,
  input  logic       freeze,
  output logic [8:0] y,
  output logic       busy,
  output logic       leg,
  output logic       jump_done,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_R6   = 3'd1,
    S_R4   = 3'd2,
    S_R2   = 3'd3,
    S_F2   = 3'd4,
    S_F4   = 3'd5,
    S_F6   = 3'd6
  } state_t;

  localparam logic [7:0] LEG_LAST = 8'(LEG_DIV - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  y_q, y_d;
  logic        pend_q, pend_d;
  logic        leg_q, leg_d;
  logic [7:0]  legdiv_q, legdiv_d;
  logic        done_q, done_d;

  logic [8:0]  step_mag;
  logic [3:0]  cnt_last;
  logic        rising;

  // Per-phase motion table: step magnitude, last count index, and direction.
  always_comb begin
    step_mag = 9'd0;
    cnt_last = 4'd0;
    rising   = 1'b0;
    case (state_q)
      S_R6: begin step_mag = 9'd6; cnt_last = 4'd9;  rising = 1'b1; end
      S_R4: begin step_mag = 9'd4; cnt_last = 4'd9;  rising = 1'b1; end
      S_R2: begin step_mag = 9'd2; cnt_last = 4'd11; rising = 1'b1; end
      S_F2: begin step_mag = 9'd2; cnt_last = 4'd11; rising = 1'b0; end
      S_F4: begin step_mag = 9'd4; cnt_last = 4'd9;  rising = 1'b0; end
      S_F6: begin step_mag = 9'd6; cnt_last = 4'd9;  rising = 1'b0; end
      default: begin step_mag = 9'd0; cnt_last = 4'd0; rising = 1'b0; end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      y_q      <= GROUND_Y;
      pend_q   <= 1'b0;
      leg_q    <= 1'b0;
      legdiv_q <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      pend_q   <= pend_d;
      leg_q    <= leg_d;
      legdiv_q <= legdiv_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; freeze holds everything and suppresses the landing pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    pend_d   = pend_q;
    leg_d    = leg_q;
    legdiv_d = legdiv_q;
    done_d   = 1'b0;
    if (!freeze) begin
      if (state_q == S_IDLE) begin
        if (tick) begin
          if (legdiv_q == LEG_LAST) begin
            leg_d    = ~leg_q;
            legdiv_d = 8'd0;
          end else begin
            legdiv_d = legdiv_q + 8'd1;
          end
        end
        // A tick coinciding with the start is consumed by IDLE, not by motion.
        if (jump_req) begin
          state_d = S_R6;
          cnt_d   = 4'd0;
        end
      end else begin
        if (state_q == S_F6 && jump_req) begin
          pend_d = 1'b1;
        end
        if (tick) begin
          y_d = rising ? (y_q - step_mag) : (y_q + step_mag);
          if (cnt_q == cnt_last) begin
            cnt_d = 4'd0;
            if (state_q == S_F6) begin
              y_d     = GROUND_Y;
              done_d  = 1'b1;
              state_d = pend_d ? S_R6 : S_IDLE;
              pend_d  = 1'b0;
            end else begin
              state_d = state_t'(state_q + 3'd1);
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
    end
  end

  // Output decode; all outputs come straight from registers.
  always_comb begin
    y         = y_q;
    busy      = (state_q != S_IDLE);
    leg       = leg_q;
    jump_done = done_q;
    phase     = state_q;
  end

endmodule
